// File: rtl/nibble_eval_sequencer.sv
// Accepts a 16-bit word, evaluates one nibble per cycle (hit iff popcount is 0, 1 or 3),
// then holds the 4-bit mask and its hit count until consumed and accumulates a saturating total.
module nibble_eval_sequencer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             clr_total,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_mask,
   output logic [2:0]       out_count,
   output logic             busy,
   output logic [CNT_W-1:0] total_hits
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EVAL = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;
   logic [15:0]      r_word;
   logic [1:0]       r_idx;
   logic [3:0]       r_mask;
   logic [2:0]       r_count;
   logic [CNT_W-1:0] r_total;
   logic [3:0]       w_nib;
   logic             w_hit;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W-1:0] w_sat;

   function automatic logic f_hit(input logic [3:0] n);
      logic [2:0] pop;
      pop = 3'(n[0]) + 3'(n[1]) + 3'(n[2]) + 3'(n[3]);
      return !((pop == 3'd2) || (pop == 3'd4));
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_in_ready  <= (w_next == S_IDLE);
         r_out_valid <= (w_next == S_HOLD);
         r_busy      <= (w_next != S_IDLE);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)        w_next = S_EVAL;
         S_EVAL:  if (r_idx == 2'd3)   w_next = S_HOLD;
         S_HOLD:  if (out_ready)       w_next = S_IDLE;
         default:                      w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_nib = r_word[3:0];
      case (r_idx)
         2'd0:    w_nib = r_word[3:0];
         2'd1:    w_nib = r_word[7:4];
         2'd2:    w_nib = r_word[11:8];
         default: w_nib = r_word[15:12];
      endcase
   end

   assign w_hit = f_hit(w_nib);
   assign w_sum = {1'b0, r_total} + (CNT_W+1)'(r_count);
   assign w_sat = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

   // Working mask/count double as the result registers; they persist through IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word  <= 16'd0;
         r_idx   <= 2'd0;
         r_mask  <= 4'd0;
         r_count <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_word  <= in_data;
                  r_idx   <= 2'd0;
                  r_mask  <= 4'd0;
                  r_count <= 3'd0;
               end
            end
            S_EVAL: begin
               r_mask[r_idx] <= w_hit;
               r_count       <= r_count + 3'(w_hit);
               if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Clear wins over a coincident completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_total <= '0;
      end else if (clr_total) begin
         r_total <= '0;
      end else if ((r_state == S_HOLD) && out_ready) begin
         r_total <= w_sat;
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign busy       = r_busy;
   assign out_mask   = r_mask;
   assign out_count  = r_count;
   assign total_hits = r_total;

endmodule

// File: tb/tb_nibble_eval_sequencer.sv
// Scoreboard bench: two instances (CNT_W=8 and CNT_W=3) share stimulus; expected results
// are queued on drive and compared when the result handshake is observed.
module tb_nibble_eval_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic        clr_total;
   logic        out_ready;

   logic        in_ready,  out_valid,  busy;
   logic [3:0]  out_mask;
   logic [2:0]  out_count;
   logic [7:0]  total8;
   logic        in_ready3, out_valid3, busy3;
   logic [3:0]  out_mask3;
   logic [2:0]  out_count3;
   logic [2:0]  total3;

   typedef struct packed {
      logic [3:0] mask;
      logic [2:0] count;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   exp8   = 0;
   int   exp3   = 0;

   nibble_eval_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .clr_total(clr_total), .out_valid(out_valid), .out_ready(out_ready),
      .out_mask(out_mask), .out_count(out_count), .busy(busy), .total_hits(total8)
   );

   nibble_eval_sequencer #(.CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
      .clr_total(clr_total), .out_valid(out_valid3), .out_ready(out_ready),
      .out_mask(out_mask3), .out_count(out_count3), .busy(busy3), .total_hits(total3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic f_ref(input logic [3:0] n);
      case (n)
         4'h0, 4'h1, 4'h2, 4'h4, 4'h7, 4'h8, 4'hB, 4'hD, 4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t model(input logic [15:0] w);
      exp_t e;
      e = '0;
      for (int k = 0; k < 4; k++) begin
         e.mask[k] = f_ref(w[4*k +: 4]);
         if (e.mask[k]) e.count = e.count + 3'd1;
      end
      return e;
   endfunction

   // Pops on handshake, predicts totals for the following edge, checks totals every cycle.
   always @(negedge clk) begin
      if (rst) begin
         exp8 = 0;
         exp3 = 0;
      end else begin
         check_eq("total8", 16'(total8), 16'(exp8));
         check_eq("total3", 16'(total3), 16'(exp3));
         mon_e = '0;
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", 16'(sb_q.size()), 16'd1);
            end else begin
               mon_e = sb_q.pop_front();
               check_eq("mask",   16'(out_mask),   16'(mon_e.mask));
               check_eq("count",  16'(out_count),  16'(mon_e.count));
               check_eq("mask3",  16'(out_mask3),  16'(mon_e.mask));
               check_eq("count3", 16'(out_count3), 16'(mon_e.count));
            end
         end
         if (clr_total) begin
            exp8 = 0;
            exp3 = 0;
         end else if (out_valid && out_ready) begin
            exp8 = (exp8 + int'(mon_e.count) > 255) ? 255 : exp8 + int'(mon_e.count);
            exp3 = (exp3 + int'(mon_e.count) > 7)   ? 7   : exp3 + int'(mon_e.count);
         end
      end
   end

   task automatic send(input logic [15:0] w, input int hold, input bit clr);
      exp_t e;
      int   t;
      e = model(w);
      t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq("idle_ready", 16'(in_ready), 16'd1);
      in_valid  = 1'b1;
      in_data   = w;
      out_ready = (hold == 0);
      sb_q.push_back(e);
      @(posedge clk); #1;
      in_data  = 16'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("eval_ready", 16'(in_ready), 16'd0);
      check_eq("eval_busy",  16'(busy),     16'd1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         in_data  = 16'($urandom);
         in_valid = (k < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (k == 4 && hold == 0) clr_total = clr;
         @(negedge clk);
         check_eq("latency",   16'(out_valid), 16'(k == 4));
         check_eq("latency3",  16'(out_valid3), 16'(k == 4));
         check_eq("busy_run",  16'(busy),      16'd1);
         check_eq("ready_run", 16'(in_ready),  16'd0);
      end
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("hold_valid", 16'(out_valid), 16'd1);
            check_eq("hold_mask",  16'(out_mask),  16'(e.mask));
            check_eq("hold_count", 16'(out_count), 16'(e.count));
            check_eq("hold_ready", 16'(in_ready),  16'd0);
            check_eq("hold_busy",  16'(busy),      16'd1);
         end
         @(posedge clk); #1;
         out_ready = 1'b1;
         clr_total = clr;
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      clr_total = 1'b0;
      in_data   = 16'($urandom);
      @(negedge clk);
      check_eq("post_ready", 16'(in_ready),  16'd1);
      check_eq("post_valid", 16'(out_valid), 16'd0);
      check_eq("post_busy",  16'(busy),      16'd0);
      check_eq("post_mask",  16'(out_mask),  16'(e.mask));
      check_eq("post_count", 16'(out_count), 16'(e.count));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] nib;
      rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; clr_total = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", 16'(in_ready),  16'd1);
      check_eq("rst_busy",  16'(busy),      16'd0);
      check_eq("rst_valid", 16'(out_valid), 16'd0);
      check_eq("rst_mask",  16'(out_mask),  16'd0);
      check_eq("rst_count", 16'(out_count), 16'd0);
      check_eq("rst_total", 16'(total8),    16'd0);

      // Accept on the first edge after reset release, then abort with reset at index 2.
      in_valid = 1'b1; in_data = 16'h1234; rst = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("first_accept", 16'(busy), 16'd1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_eq("abort_state", 16'(busy),      16'd0);
      check_eq("abort_ready", 16'(in_ready),  16'd1);
      check_eq("abort_valid", 16'(out_valid), 16'd0);
      check_eq("abort_mask",  16'(out_mask),  16'd0);
      check_eq("abort_count", 16'(out_count), 16'd0);
      check_eq("abort_total", 16'(total8),    16'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;

      send(16'h0000, 0, 1'b0);
      send(16'hF3E1, 0, 1'b0);
      send(16'h5A6C, 3, 1'b0);
      for (int v = 0; v < 16; v++) begin
         nib = 4'(v);
         send({nib, nib, nib, nib}, 0, 1'b0);
      end
      for (int i = 0; i < 6; i++) send(16'($urandom), int'($urandom_range(0, 2)), 1'b0);

      // Clear, then saturate the narrow total and clear on a completion edge.
      @(posedge clk); #1;
      clr_total = 1'b1;
      @(posedge clk); #1;
      clr_total = 1'b0;
      send(16'h0000, 0, 1'b0);
      send(16'h0000, 0, 1'b0);
      check_eq("sat3", 16'(total3), 16'd7);
      send(16'h0000, 1, 1'b1);
      check_eq("clr_on_done", 16'(total3), 16'd0);
      check_eq("sb_drained", 16'(sb_q.size()), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
